// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared state encoding and ASCII constants for the countdown display
package display_pkg;

    typedef enum logic [5:0] {
        ST_IDLE    = 6'b000001,
        ST_SEND    = 6'b000010,
        ST_WAIT_TX = 6'b000100,
        ST_DELAY   = 6'b001000,
        ST_STEP    = 6'b010000,
        ST_FINISH  = 6'b100000
    } state_t;

    localparam logic [7:0] ESC      = 8'h1B;
    localparam logic [7:0] LBRACKET = 8'h5B;
    localparam logic [7:0] CHAR_J   = 8'h6A;
    localparam logic [7:0] ASCII0   = 8'h30;

    localparam int PREFIX_LEN = 3;

endpackage

// File: rtl/bin_to_ascii_digits.sv
// rtl/bin_to_ascii_digits.sv - combinational double-dabble binary to ASCII decimal digits
module bin_to_ascii_digits #(
    parameter int VALUE_W = 10,
    parameter int DIGITS  = 3
) (
    input  logic [VALUE_W-1:0]  bin,
    output logic [DIGITS*8-1:0] ascii
);

    localparam int SH_W = VALUE_W + 4 * DIGITS;

    logic [SH_W-1:0] sh;

    // BCD digits accumulate above the binary field as it is shifted out the top
    always_comb begin
        sh = {{(4 * DIGITS){1'b0}}, bin};
        for (int i = 0; i < VALUE_W; i++) begin
            for (int d = 0; d < DIGITS; d++) begin
                if (sh[VALUE_W + 4 * d +: 4] >= 4'd5)
                    sh[VALUE_W + 4 * d +: 4] = sh[VALUE_W + 4 * d +: 4] + 4'd3;
            end
            sh = sh << 1;
        end
        ascii = '0;
        for (int d = 0; d < DIGITS; d++)
            ascii[d * 8 +: 8] = {4'h3, sh[VALUE_W + 4 * d +: 4]};
    end

endmodule

// File: rtl/countdown_display_ctrl.sv
// rtl/countdown_display_ctrl.sv - count down/up timer that streams its value to a display via the SPI byte master
module countdown_display_ctrl
    import display_pkg::*;
#(
    parameter int VALUE_W   = 10,
    parameter int DIGITS    = 3,
    parameter int MAX_VALUE = 999,
    parameter int TICK_DIV  = 12500
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               set,
    input  logic [VALUE_W-1:0] load_value,
    input  logic               count_up,
    input  logic               start,
    input  logic               suspend,
    input  logic               restart,
    input  logic               turn_zero,
    input  logic               end_transmission,
    output logic [7:0]         data_out,
    output logic               begin_transmission,
    output logic               slave_select,
    output logic               done,
    output logic [5:0]         state
);

    localparam int LEN   = PREFIX_LEN + DIGITS;
    localparam int IDX_W = $clog2(LEN);
    localparam int CNT_W = $clog2(TICK_DIV);

    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(LEN - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [VALUE_W-1:0] MAX_V    = VALUE_W'(MAX_VALUE);

    state_t               cur_state;
    logic [IDX_W-1:0]     idx;
    logic [CNT_W-1:0]     delay_cnt;
    logic [VALUE_W-1:0]   value;
    logic [VALUE_W-1:0]   target;
    logic                 mode;
    logic                 fin;

    logic [VALUE_W-1:0]   sat_load;
    logic [VALUE_W-1:0]   init_value;
    logic [VALUE_W-1:0]   term_value;
    logic [VALUE_W-1:0]   step_value;
    logic [IDX_W-1:0]     next_idx;
    logic [7:0]           next_byte;
    logic [DIGITS*8-1:0]  digits_ascii;

    bin_to_ascii_digits #(
        .VALUE_W (VALUE_W),
        .DIGITS  (DIGITS)
    ) u_digits (
        .bin   (value),
        .ascii (digits_ascii)
    );

    assign sat_load   = (load_value > MAX_V) ? MAX_V : load_value;
    assign init_value = mode ? '0 : target;
    assign term_value = mode ? target : '0;
    assign step_value = mode ? value + VALUE_W'(1) : value - VALUE_W'(1);
    assign next_idx   = idx + IDX_W'(1);

    // Byte for the following index; value is stable while a message is in flight
    always_comb begin
        next_byte = 8'h00;
        for (int j = 0; j < DIGITS; j++) begin
            if (int'(next_idx) == PREFIX_LEN + j)
                next_byte = digits_ascii[(DIGITS - 1 - j) * 8 +: 8];
        end
        if (next_idx == IDX_W'(1)) next_byte = LBRACKET;
        if (next_idx == IDX_W'(2)) next_byte = CHAR_J;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state    <= ST_IDLE;
            idx          <= '0;
            delay_cnt    <= '0;
            value        <= '0;
            target       <= '0;
            mode         <= 1'b0;
            fin          <= 1'b0;
            data_out     <= 8'h00;
            slave_select <= 1'b1;
        end else begin
            case (cur_state)
                ST_IDLE: begin
                    value <= set ? sat_load : '0;
                    if (start && set) begin
                        mode         <= count_up;
                        target       <= sat_load;
                        value        <= count_up ? '0 : sat_load;
                        fin          <= (sat_load == '0);
                        idx          <= '0;
                        data_out     <= ESC;
                        slave_select <= 1'b0;
                        cur_state    <= ST_SEND;
                    end
                end
                ST_SEND: cur_state <= ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (end_transmission) begin
                        if (idx != IDX_LAST) begin
                            idx       <= next_idx;
                            data_out  <= next_byte;
                            cur_state <= ST_SEND;
                        end else begin
                            idx          <= '0;
                            slave_select <= 1'b1;
                            cur_state    <= fin ? ST_FINISH : ST_DELAY;
                        end
                    end
                end
                ST_DELAY, ST_STEP: begin
                    if (turn_zero) begin
                        value        <= term_value;
                        fin          <= 1'b1;
                        delay_cnt    <= '0;
                        data_out     <= ESC;
                        slave_select <= 1'b0;
                        cur_state    <= ST_SEND;
                    end else if (restart) begin
                        value        <= init_value;
                        fin          <= (init_value == term_value);
                        delay_cnt    <= '0;
                        data_out     <= ESC;
                        slave_select <= 1'b0;
                        cur_state    <= ST_SEND;
                    end else if (!suspend) begin
                        if (cur_state == ST_STEP) begin
                            value        <= step_value;
                            fin          <= (step_value == term_value);
                            data_out     <= ESC;
                            slave_select <= 1'b0;
                            cur_state    <= ST_SEND;
                        end else if (delay_cnt == CNT_LAST) begin
                            delay_cnt <= '0;
                            cur_state <= ST_STEP;
                        end else begin
                            delay_cnt <= delay_cnt + CNT_W'(1);
                        end
                    end
                end
                ST_FINISH: if (!start && !set) cur_state <= ST_IDLE;
                default:   cur_state <= ST_IDLE;
            endcase
        end
    end

    assign begin_transmission = (cur_state == ST_SEND);
    assign done               = (cur_state == ST_FINISH);
    assign state              = cur_state;

endmodule

// File: tb/tb_countdown_display_ctrl.sv
// tb/tb_countdown_display_ctrl.sv - scoreboard bench for countdown_display_ctrl with SPI responder
module tb_countdown_display_ctrl;

    localparam int VALUE_W   = 11;
    localparam int DIGITS    = 3;
    localparam int MAX_VALUE = 999;
    localparam int TICK_DIV  = 4;

    localparam int A_NONE = 0, A_SUSP = 1, A_RS = 2, A_TZ = 3, A_TZW = 4;

    logic clk = 1'b0, rst = 1'b1, set = 1'b0, count_up = 1'b0, start = 1'b0;
    logic suspend = 1'b0, restart = 1'b0, turn_zero = 1'b0, end_transmission = 1'b0;
    logic [VALUE_W-1:0] load_value = '0;
    logic [7:0] data_out;
    logic begin_transmission, slave_select, done;
    logic [5:0] state;

    int n_cmp = 0;
    int n_bad = 0;
    logic [47:0] exp_q[$];
    int act_kind[64];
    int act_k[64];

    always #5 clk = ~clk;

    countdown_display_ctrl #(
        .VALUE_W   (VALUE_W),
        .DIGITS    (DIGITS),
        .MAX_VALUE (MAX_VALUE),
        .TICK_DIV  (TICK_DIV)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .set                (set),
        .load_value         (load_value),
        .count_up           (count_up),
        .start              (start),
        .suspend            (suspend),
        .restart            (restart),
        .turn_zero          (turn_zero),
        .end_transmission   (end_transmission),
        .data_out           (data_out),
        .begin_transmission (begin_transmission),
        .slave_select       (slave_select),
        .done               (done),
        .state              (state)
    );

    task automatic check(string name, logic [63:0] got, logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic logic [47:0] msg_of(int v);
        return {8'h1B, 8'h5B, 8'h6A, 8'(48 + (v / 100) % 10), 8'(48 + (v / 10) % 10), 8'(48 + v % 10)};
    endfunction

    // Reference: the sequence of displayed values, one message per value
    function automatic int build_model(int load, bit up);
        int target = (load > MAX_VALUE) ? MAX_VALUE : load;
        int init   = up ? 0 : target;
        int term   = up ? target : 0;
        int v      = init;
        int n      = 1;
        exp_q.push_back(msg_of(v));
        while (v != term && n < 64) begin
            case (act_kind[n-1])
                A_TZ:    v = term;
                A_RS:    v = init;
                default: v = up ? v + 1 : v - 1;
            endcase
            exp_q.push_back(msg_of(v));
            n++;
        end
        return n;
    endfunction

    // SPI master: end_transmission lands 5 cycles after each begin_transmission
    initial begin
        forever begin
            @(negedge clk);
            if (begin_transmission === 1'b1) begin
                repeat (4) @(posedge clk);
                #2 end_transmission = 1'b1;
                @(posedge clk);
                #2 end_transmission = 1'b0;
            end
        end
    end

    initial begin
        logic [47:0] cur;
        logic [7:0]  last;
        int          nb;
        bit          pend;
        cur = '0; last = '0; nb = 0; pend = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                nb = 0;
                pend = 1'b0;
            end else begin
                if (end_transmission && pend) begin
                    check("data_stable", data_out, last);
                    pend = 1'b0;
                end
                if (begin_transmission === 1'b1) begin
                    check("ss_low_in_send", slave_select, 0);
                    cur  = {cur[39:0], data_out};
                    last = data_out;
                    pend = 1'b1;
                    nb++;
                    if (nb == 6) begin
                        check("scoreboard_nonempty", exp_q.size() != 0, 1);
                        if (exp_q.size() != 0) check("message", cur, exp_q.pop_front());
                        nb = 0;
                    end
                end
            end
        end
    end

    task automatic wait_msg_end(output bit ok);
        int c = 0;
        bit seen_low = 1'b0;
        while (slave_select !== 1'b0 && c < 1000) begin @(negedge clk); c++; end
        seen_low = (slave_select === 1'b0);
        while (slave_select !== 1'b1 && c < 2000) begin @(negedge clk); c++; end
        ok = seen_low && (slave_select === 1'b1);
        check("msg_end_in_time", ok, 1);
    endtask

    task automatic apply_act(int m);
        int c;
        case (act_kind[m])
            A_SUSP: begin
                suspend = 1'b1;
                repeat (act_k[m]) @(negedge clk);
                suspend = 1'b0;
                c = act_k[m];
                while (begin_transmission !== 1'b1 && c < 500) begin @(negedge clk); c++; end
                check("suspend_gap", c, TICK_DIV + 1 + act_k[m]);
            end
            A_RS: begin
                restart = 1'b1;
                @(negedge clk);
                restart = 1'b0;
            end
            A_TZ: begin
                turn_zero = 1'b1;
                @(negedge clk);
                turn_zero = 1'b0;
            end
            A_TZW: begin
                c = 0;
                while (begin_transmission !== 1'b1 && c < 500) begin @(negedge clk); c++; end
                repeat (2) @(negedge clk);
                turn_zero = 1'b1;
                @(negedge clk);
                turn_zero = 1'b0;
            end
            default: ;
        endcase
    endtask

    task automatic run(int load, bit up);
        int n;
        bit ok;
        bit extra;
        n = build_model(load, up);
        @(negedge clk);
        load_value = VALUE_W'(load);
        count_up = up;
        set = 1'b1;
        start = 1'b1;
        @(posedge clk);
        #1;
        check("start_begin_tx", begin_transmission, 1);
        check("start_ss", slave_select, 0);
        check("start_byte", data_out, 8'h1B);
        for (int m = 0; m < n; m++) begin
            wait_msg_end(ok);
            if (!ok) break;
            if (m < n - 1) apply_act(m);
        end
        check("done_after_last", done, 1);
        extra = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (begin_transmission === 1'b1) extra = 1'b1;
        end
        check("no_extra_tx", extra, 0);
        check("done_held", done, 1);
        check("scoreboard_drained", exp_q.size(), 0);
        set = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("idle_after_drop", state, 6'b000001);
        exp_q.delete();
        for (int i = 0; i < 64; i++) begin act_kind[i] = A_NONE; act_k[i] = 0; end
    endtask

    task automatic reset_mid_msg();
        int c = 0;
        int nbt = 0;
        exp_q.push_back(msg_of(MAX_VALUE));
        @(negedge clk);
        load_value = 11'd1200;
        count_up = 1'b0;
        set = 1'b1;
        start = 1'b1;
        while (nbt < 9 && c < 2000) begin
            @(negedge clk);
            c++;
            if (begin_transmission === 1'b1) nbt++;
        end
        check("reached_msg2_byte2", nbt, 9);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        set = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        check("rst_state", state, 6'b000001);
        check("rst_ss", slave_select, 1);
        check("rst_begin_tx", begin_transmission, 0);
        check("rst_data_out", data_out, 8'h00);
        check("sat_msg_seen", exp_q.size(), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        exp_q.delete();
    endtask

    initial begin
        int  load;
        bit  up;
        int  rs_at;
        bit  use_rs;
        int  p;
        for (int i = 0; i < 64; i++) begin act_kind[i] = A_NONE; act_k[i] = 0; end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data_out", data_out, 8'h00);
        check("reset_begin_tx", begin_transmission, 0);
        check("reset_ss", slave_select, 1);
        check("reset_done", done, 0);
        check("reset_state", state, 6'b000001);
        rst = 1'b0;
        @(negedge clk);
        check("idle_after_reset", state, 6'b000001);

        run(25, 1'b0);

        act_kind[2]  = A_SUSP; act_k[2] = 10;
        act_kind[8]  = A_RS;
        act_kind[10] = A_TZW;
        act_kind[22] = A_TZ;
        run(25, 1'b0);

        run(3, 1'b1);

        for (int r = 0; r < 3; r++) begin
            load   = $urandom_range(0, 30);
            up     = 1'($urandom_range(0, 1));
            rs_at  = $urandom_range(0, 6);
            use_rs = 1'($urandom_range(0, 1));
            for (int i = 0; i < 64; i++) begin
                p = $urandom_range(0, 19);
                if (p < 3) begin
                    act_kind[i] = A_SUSP;
                    act_k[i] = $urandom_range(0, 12);
                end else if (p == 3) begin
                    act_kind[i] = A_TZW;
                end else if (p == 4 && i > 3) begin
                    act_kind[i] = A_TZ;
                end
            end
            if (use_rs) act_kind[rs_at] = A_RS;
            run(load, up);
        end

        reset_mid_msg();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
